alu_exec_ctrl: RTL and testbench

//  Sequencer for the combinational data-processing ALU in the execute stage. Accepts one decoded

---
 rtl/alu_exec_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the data-processing ALU: accepts one decoded op, tests its
// ARM condition against the owned CNZV flag register, drives the ALU and hands off writeback.
module alu_exec_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             in_Clk,
  input  logic             in_Rst,
  input  logic             in_Valid,
  output logic             out_Ready,
  input  logic [3:0]       in_Cond,
  input  logic [3:0]       in_Opcode,
  input  logic             in_Set_cond,
  input  logic [3:0]       in_Rd,
  input  logic [WIDTH-1:0] in_Rn_val,
  input  logic [WIDTH-1:0] in_Op2_val,
  input  logic             in_Barrel_carry,
  output logic [WIDTH-1:0] out_Alu_Rn,
  output logic [WIDTH-1:0] out_Alu_Op2,
  output logic             out_Alu_Barrel_carry,
  output logic [3:0]       out_Alu_Opcode,
  output logic [3:0]       out_Alu_CNZV,
  output logic             out_Alu_Set_cond,
  input  logic [WIDTH-1:0] in_Alu_Y,
  input  logic [3:0]       in_Alu_CNZV,
  input  logic             in_Alu_Writeback,
  input  logic             in_Flags_we,
  input  logic [3:0]       in_Flags_data,
  output logic [3:0]       out_CNZV,
  output logic             out_Wb_valid,
  input  logic             in_Wb_ready,
  output logic [3:0]       out_Wb_Rd,
  output logic [WIDTH-1:0] out_Wb_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;

  logic [3:0]       cond_q;
  logic [3:0]       opcode_q;
  logic             set_cond_q;
  logic [3:0]       rd_q;
  logic [WIDTH-1:0] rn_q;
  logic [WIDTH-1:0] op2_q;
  logic             barrel_carry_q;

  logic [3:0]       flags_q, flags_d;
  logic             wb_valid_q, wb_valid_d;
  logic [3:0]       wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  logic             capture;
  logic             ready_st;
  logic             alu_set_cond;
  logic             exec_pass;

  // Flag vector layout is {C, N, Z, V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] cnzv);
    logic c, n, z, v;
    logic r;
    c = cnzv[3];
    n = cnzv[2];
    z = cnzv[1];
    v = cnzv[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c && !z;
      4'b1001: r = !c || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign exec_pass = cond_pass(cond_q, flags_q);

  always_comb begin
    state_d      = state_q;
    flags_d      = in_Flags_we ? in_Flags_data : flags_q;
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    capture      = 1'b0;
    ready_st     = 1'b0;
    alu_set_cond = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_st = 1'b1;
        if (in_Valid) begin
          capture = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (exec_pass) begin
          alu_set_cond = set_cond_q;
          // An ALU flag update overrides a same-cycle direct flag write.
          if (set_cond_q) flags_d = in_Alu_CNZV;
          if (in_Alu_Writeback) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = in_Alu_Y;
            state_d    = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (in_Wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state_q    <= ST_IDLE;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Captured op fields stay put until the next accept so the ALU inputs are stable in EXEC.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      cond_q         <= '0;
      opcode_q       <= '0;
      set_cond_q     <= 1'b0;
      rd_q           <= '0;
      rn_q           <= '0;
      op2_q          <= '0;
      barrel_carry_q <= 1'b0;
    end else if (capture) begin
      cond_q         <= in_Cond;
      opcode_q       <= in_Opcode;
      set_cond_q     <= in_Set_cond;
      rd_q           <= in_Rd;
      rn_q           <= in_Rn_val;
      op2_q          <= in_Op2_val;
      barrel_carry_q <= in_Barrel_carry;
    end
  end

  assign out_Ready            = ready_st && !in_Rst;
  assign out_Alu_Rn           = rn_q;
  assign out_Alu_Op2          = op2_q;
  assign out_Alu_Barrel_carry = barrel_carry_q;
  assign out_Alu_Opcode       = opcode_q;
  assign out_Alu_CNZV         = flags_q;
  assign out_Alu_Set_cond     = alu_set_cond;
  assign out_CNZV             = flags_q;
  assign out_Wb_valid         = wb_valid_q;
  assign out_Wb_Rd            = wb_rd_q;
  assign out_Wb_data          = wb_data_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl; a small behavioural ALU closes the loop around the DUT.
module tb_alu_exec_ctrl;

  localparam int WIDTH = 32;

  logic             in_Clk = 1'b0;
  logic             in_Rst;
  logic             in_Valid;
  logic             out_Ready;
  logic [3:0]       in_Cond;
  logic [3:0]       in_Opcode;
  logic             in_Set_cond;
  logic [3:0]       in_Rd;
  logic [WIDTH-1:0] in_Rn_val;
  logic [WIDTH-1:0] in_Op2_val;
  logic             in_Barrel_carry;
  logic [WIDTH-1:0] out_Alu_Rn;
  logic [WIDTH-1:0] out_Alu_Op2;
  logic             out_Alu_Barrel_carry;
  logic [3:0]       out_Alu_Opcode;
  logic [3:0]       out_Alu_CNZV;
  logic             out_Alu_Set_cond;
  logic [WIDTH-1:0] in_Alu_Y;
  logic [3:0]       in_Alu_CNZV;
  logic             in_Alu_Writeback;
  logic             in_Flags_we;
  logic [3:0]       in_Flags_data;
  logic [3:0]       out_CNZV;
  logic             out_Wb_valid;
  logic             in_Wb_ready;
  logic [3:0]       out_Wb_Rd;
  logic [WIDTH-1:0] out_Wb_data;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] C_EQ = 4'b0000;
  localparam logic [3:0] C_NE = 4'b0001;
  localparam logic [3:0] C_AL = 4'b1110;
  localparam logic [3:0] C_NV = 4'b1111;

  alu_exec_ctrl #(.WIDTH(WIDTH)) dut (
    .in_Clk(in_Clk), .in_Rst(in_Rst), .in_Valid(in_Valid), .out_Ready(out_Ready),
    .in_Cond(in_Cond), .in_Opcode(in_Opcode), .in_Set_cond(in_Set_cond), .in_Rd(in_Rd),
    .in_Rn_val(in_Rn_val), .in_Op2_val(in_Op2_val), .in_Barrel_carry(in_Barrel_carry),
    .out_Alu_Rn(out_Alu_Rn), .out_Alu_Op2(out_Alu_Op2),
    .out_Alu_Barrel_carry(out_Alu_Barrel_carry), .out_Alu_Opcode(out_Alu_Opcode),
    .out_Alu_CNZV(out_Alu_CNZV), .out_Alu_Set_cond(out_Alu_Set_cond),
    .in_Alu_Y(in_Alu_Y), .in_Alu_CNZV(in_Alu_CNZV), .in_Alu_Writeback(in_Alu_Writeback),
    .in_Flags_we(in_Flags_we), .in_Flags_data(in_Flags_data), .out_CNZV(out_CNZV),
    .out_Wb_valid(out_Wb_valid), .in_Wb_ready(in_Wb_ready), .out_Wb_Rd(out_Wb_Rd),
    .out_Wb_data(out_Wb_data)
  );

  always #5 in_Clk = ~in_Clk;

  // Behavioural ALU for the handful of opcodes the directed steps use.
  always_comb begin
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] a, b, y;
    logic             c, v;
    a    = out_Alu_Rn;
    b    = out_Alu_Op2;
    wide = '0;
    y    = a;
    c    = out_Alu_CNZV[3];
    v    = out_Alu_CNZV[0];
    case (out_Alu_Opcode)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        y = a - b;
        c = (a >= b);
        v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MOV: begin
        y = b;
        c = out_Alu_Barrel_carry;
      end
      default: ;
    endcase
    in_Alu_Y         = y;
    in_Alu_CNZV      = {c, y[WIDTH-1], (y == '0), v};
    in_Alu_Writeback = (out_Alu_Opcode[3:2] != 2'b10);
  end

  task automatic step();
    @(posedge in_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [3:0] cond, input logic [3:0] op, input logic s,
                         input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2);
    in_Valid    = 1'b1;
    in_Cond     = cond;
    in_Opcode   = op;
    in_Set_cond = s;
    in_Rd       = rd;
    in_Rn_val   = rn;
    in_Op2_val  = op2;
  endtask

  // Accept happens on the next edge; returns with the DUT in EXEC.
  task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2);
    present(cond, op, s, rd, rn, op2);
    step();
    in_Valid = 1'b0;
  endtask

  initial begin
    in_Rst = 1'b1; in_Valid = 1'b0; in_Cond = '0; in_Opcode = '0; in_Set_cond = 1'b0;
    in_Rd = '0; in_Rn_val = '0; in_Op2_val = '0; in_Barrel_carry = 1'b0;
    in_Flags_we = 1'b0; in_Flags_data = '0; in_Wb_ready = 1'b1;

    // Reset
    step(); step();
    check("rst_ready", out_Ready, 0);
    check("rst_flags", out_CNZV, 4'b0000);
    check("rst_wbvalid", out_Wb_valid, 0);
    check("rst_wbdata", out_Wb_data, 0);
    in_Rst = 1'b0;
    #1;
    check("idle_ready", out_Ready, 1);

    // ADD 2,3 AL S=1 Rd=4
    issue(C_AL, OP_ADD, 1'b1, 4'd4, 32'd2, 32'd3);
    check("add_exec_ready", out_Ready, 0);
    check("add_exec_rn", out_Alu_Rn, 2);
    check("add_exec_setcond", out_Alu_Set_cond, 1);
    step();
    check("add_wbvalid", out_Wb_valid, 1);
    check("add_wbrd", out_Wb_Rd, 4);
    check("add_wbdata", out_Wb_data, 5);
    check("add_flags", out_CNZV, 4'b0000);
    step();
    check("add_wb_done", out_Wb_valid, 0);
    check("add_idle_ready", out_Ready, 1);

    // SUB 5,5 AL S=1 -> C and Z
    issue(C_AL, OP_SUB, 1'b1, 4'd1, 32'd5, 32'd5);
    step();
    check("sub_flags", out_CNZV, 4'b1010);
    check("sub_wbdata", out_Wb_data, 0);
    step();

    // ADD EQ passes with Z set
    issue(C_EQ, OP_ADD, 1'b0, 4'd2, 32'd1, 32'd2);
    step();
    check("addeq_wbvalid", out_Wb_valid, 1);
    check("addeq_wbdata", out_Wb_data, 3);
    check("addeq_flags", out_CNZV, 4'b1010);
    step();

    // ADD NE is skipped
    issue(C_NE, OP_ADD, 1'b1, 4'd3, 32'd7, 32'd8);
    check("addne_setcond", out_Alu_Set_cond, 0);
    step();
    check("addne_wbvalid", out_Wb_valid, 0);
    check("addne_flags", out_CNZV, 4'b1010);
    check("addne_ready", out_Ready, 1);

    // CMP 3,7: no writeback, N=1 C=0
    issue(C_AL, OP_CMP, 1'b1, 4'd0, 32'd3, 32'd7);
    step();
    check("cmp_wbvalid", out_Wb_valid, 0);
    check("cmp_flags", out_CNZV, 4'b0100);
    check("cmp_ready", out_Ready, 1);

    // Backpressure on writeback with a competing op offered
    in_Wb_ready = 1'b0;
    issue(C_AL, OP_ADD, 1'b0, 4'd5, 32'd1, 32'd1);
    step();
    present(C_AL, OP_MOV, 1'b1, 4'd9, 32'd99, 32'd99);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", out_Ready, 0);
      check("bp_wbvalid", out_Wb_valid, 1);
      check("bp_wbdata", out_Wb_data, 2);
      check("bp_wbrd", out_Wb_Rd, 5);
      step();
    end
    in_Valid = 1'b0;
    in_Wb_ready = 1'b1;
    step();
    check("bp_release_wbvalid", out_Wb_valid, 0);
    check("bp_release_ready", out_Ready, 1);
    check("bp_not_captured_rn", out_Alu_Rn, 1);
    check("bp_not_captured_op", out_Alu_Opcode, OP_ADD);

    // NV never executes
    issue(C_NV, OP_ADD, 1'b1, 4'd6, 32'd0, 32'd0);
    check("nv_setcond", out_Alu_Set_cond, 0);
    step();
    check("nv_flags", out_CNZV, 4'b0100);
    check("nv_wbvalid", out_Wb_valid, 0);

    // Direct flag write in IDLE
    in_Flags_we = 1'b1; in_Flags_data = 4'b0101;
    step();
    in_Flags_we = 1'b0;
    check("fwe_flags", out_CNZV, 4'b0101);

    // Direct write colliding with ALU update in EXEC: ALU wins
    issue(C_AL, OP_ADD, 1'b1, 4'd7, 32'd2, 32'd3);
    in_Flags_we = 1'b1; in_Flags_data = 4'b1111;
    step();
    in_Flags_we = 1'b0;
    check("coll_flags", out_CNZV, 4'b0000);
    check("coll_wbdata", out_Wb_data, 5);
    step();

    // Reset while in RESP
    in_Flags_we = 1'b1; in_Flags_data = 4'b0101;
    step();
    in_Flags_we = 1'b0;
    in_Wb_ready = 1'b0;
    issue(C_AL, OP_ADD, 1'b0, 4'd8, 32'd1, 32'd1);
    step();
    check("rresp_wbvalid", out_Wb_valid, 1);
    in_Rst = 1'b1;
    step();
    in_Rst = 1'b0;
    #1;
    check("rresp_after_wbvalid", out_Wb_valid, 0);
    check("rresp_after_flags", out_CNZV, 4'b0000);
    check("rresp_after_ready", out_Ready, 1);
    check("rresp_after_wbdata", out_Wb_data, 0);
    check("rresp_after_wbrd", out_Wb_Rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
